// File: rtl/packet_decoder.sv
// rtl/packet_decoder.sv - UART packet decoder with sync byte, XOR checksum and inter-byte timeout
//
// Purpose: assembles SYNC_BYTE-framed packets from a UART byte stream, checks
// the XOR checksum and presents the decoded fields as registered outputs.
//
// Ports:
//   clk, rst            - rising-edge clock, synchronous active-high reset
//   i_data              - received byte, qualified by i_rx_done_tick
//   i_rx_done_tick      - one-cycle strobe per received byte
//   o_output_pattern    - decoded output pattern (DATA_BIT)
//   o_freq_pattern      - decoded frequency pattern (DATA_BIT)
//   o_sel_out           - decoded channel select (SEL_BIT)
//   o_mode, o_stop      - decoded flags
//   o_start             - one-cycle pulse when an accepted packet has start set
//   o_done_tick         - one-cycle pulse per accepted packet
//   o_err_tick          - one-cycle pulse per checksum failure or timeout
//   o_err_cnt           - saturating error count
module packet_decoder #(
  parameter int          DATA_BIT  = 16,
  parameter int          SEL_BIT   = 4,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int          TIMEOUT   = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          i_data,
  input  logic                i_rx_done_tick,
  output logic [DATA_BIT-1:0] o_output_pattern,
  output logic [DATA_BIT-1:0] o_freq_pattern,
  output logic [SEL_BIT-1:0]  o_sel_out,
  output logic                o_mode,
  output logic                o_stop,
  output logic                o_start,
  output logic                o_done_tick,
  output logic                o_err_tick,
  output logic [7:0]          o_err_cnt
);

  localparam int PACK_NUM = (2*DATA_BIT+3+SEL_BIT+7)/8;
  localparam int PW       = PACK_NUM*8;
  localparam int USED     = 2*DATA_BIT+3+SEL_BIT;
  localparam int CW       = $clog2(PACK_NUM+1);
  localparam int TW       = $clog2(TIMEOUT+1);

  localparam logic [CW-1:0] LAST_BYTE = CW'(PACK_NUM-1);
  // The idle cycle that would bring the counter to TIMEOUT-1 is the one that expires.
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT-2);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_CHK, S_DONE} state_t;

  state_t         state;
  logic [CW-1:0]  byte_cnt;
  logic [PW-1:0]  payload;
  logic [7:0]     run_xor;
  logic [TW-1:0]  to_cnt;

  // Padding bits above the last field are deliberately never decoded.
  logic unused_bits;
  assign unused_bits = ^(payload >> USED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      byte_cnt         <= '0;
      payload          <= '0;
      run_xor          <= '0;
      to_cnt           <= '0;
      o_output_pattern <= '0;
      o_freq_pattern   <= '0;
      o_sel_out        <= '0;
      o_mode           <= 1'b0;
      o_stop           <= 1'b0;
      o_start          <= 1'b0;
      o_done_tick      <= 1'b0;
      o_err_tick       <= 1'b0;
      o_err_cnt        <= '0;
    end else begin
      o_done_tick <= 1'b0;
      o_start     <= 1'b0;
      o_err_tick  <= 1'b0;

      case (state)
        // S_DONE lasts one cycle but already listens for the next sync byte.
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (i_rx_done_tick && i_data == SYNC_BYTE) begin
            state    <= S_DATA;
            byte_cnt <= '0;
            payload  <= '0;
            run_xor  <= '0;
            to_cnt   <= '0;
          end
        end

        S_DATA, S_CHK: begin
          if (i_rx_done_tick) begin
            to_cnt <= '0;
            if (state == S_DATA) begin
              // Bytes arrive LSB first, so each new byte enters at the top.
              payload  <= (payload >> 8) | (PW'(i_data) << (PW-8));
              run_xor  <= run_xor ^ i_data;
              byte_cnt <= byte_cnt + 1'b1;
              if (byte_cnt == LAST_BYTE) state <= S_CHK;
            end else if (i_data == run_xor) begin
              state            <= S_DONE;
              o_output_pattern <= payload[DATA_BIT-1:0];
              o_freq_pattern   <= payload[2*DATA_BIT-1:DATA_BIT];
              o_start          <= payload[2*DATA_BIT];
              o_stop           <= payload[2*DATA_BIT+1];
              o_mode           <= payload[2*DATA_BIT+2];
              o_sel_out        <= payload[2*DATA_BIT+3 +: SEL_BIT];
              o_done_tick      <= 1'b1;
            end else begin
              state      <= S_IDLE;
              o_err_tick <= 1'b1;
              if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 1'b1;
            end
          end else if (to_cnt == TO_LAST) begin
            state      <= S_IDLE;
            o_err_tick <= 1'b1;
            if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_decoder.sv
// tb/tb_packet_decoder.sv - directed self-checking bench for packet_decoder
module tb_packet_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data;
  logic        tick;
  logic [15:0] out_pat;
  logic [15:0] freq_pat;
  logic [3:0]  sel;
  logic        mode, stop, start, done, err;
  logic [7:0]  err_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_err = 0;

  always #5 clk = ~clk;

  packet_decoder dut (
    .clk(clk), .rst(rst), .i_data(data), .i_rx_done_tick(tick),
    .o_output_pattern(out_pat), .o_freq_pattern(freq_pat), .o_sel_out(sel),
    .o_mode(mode), .o_stop(stop), .o_start(start),
    .o_done_tick(done), .o_err_tick(err), .o_err_cnt(err_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge with the byte consumed.
  task automatic tick_byte(input logic [7:0] b);
    data = b;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic send_packet(input logic [7:0] p0, p1, p2, p3, p4, chk);
    tick_byte(8'hA5);
    tick_byte(p0); tick_byte(p1); tick_byte(p2); tick_byte(p3); tick_byte(p4);
    tick_byte(chk);
  endtask

  task automatic expect_accept(input string tag, input logic st, input logic [15:0] o,
                               input logic [15:0] f, input logic m, input logic sp,
                               input logic [3:0] s);
    check_eq({tag, " done"},  done, 1'b1);
    check_eq({tag, " err"},   err, 1'b0);
    check_eq({tag, " start"}, start, st);
    check_eq({tag, " out"},   out_pat, o);
    check_eq({tag, " freq"},  freq_pat, f);
    check_eq({tag, " mode"},  mode, m);
    check_eq({tag, " stop"},  stop, sp);
    check_eq({tag, " sel"},   sel, s);
    check_eq({tag, " errcnt"}, err_cnt, exp_err);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, " out"},    out_pat, 16'h0);
    check_eq({tag, " freq"},   freq_pat, 16'h0);
    check_eq({tag, " sel"},    sel, 4'h0);
    check_eq({tag, " flags"},  {mode, stop, start, done, err}, 5'b0);
    check_eq({tag, " errcnt"}, err_cnt, 8'h0);
  endtask

  initial begin
    rst  = 1'b1;
    data = 8'h00;
    tick = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Good packet
    send_packet(8'h34, 8'h12, 8'h78, 8'h56, 8'h25, 8'h2D);
    expect_accept("good", 1'b1, 16'h1234, 16'h5678, 1'b1, 1'b0, 4'h4);
    @(negedge clk);
    check_eq("good pulse end", {done, start, err}, 3'b000);
    check_eq("good hold out", out_pat, 16'h1234);

    // Bad checksum
    send_packet(8'h34, 8'h12, 8'h78, 8'h56, 8'h25, 8'h2C);
    exp_err = 1;
    check_eq("badchk err", err, 1'b1);
    check_eq("badchk done", done, 1'b0);
    check_eq("badchk errcnt", err_cnt, exp_err);
    check_eq("badchk out", out_pat, 16'h1234);
    check_eq("badchk freq", freq_pat, 16'h5678);
    @(negedge clk);
    check_eq("badchk pulse end", err, 1'b0);

    // Garbage before sync
    tick_byte(8'h00); tick_byte(8'hFF); tick_byte(8'h12);
    send_packet(8'h34, 8'h12, 8'h78, 8'h56, 8'h25, 8'h2D);
    expect_accept("garbage", 1'b1, 16'h1234, 16'h5678, 1'b1, 1'b0, 4'h4);
    @(negedge clk);

    // Sync byte value inside the payload is plain data
    send_packet(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5);
    expect_accept("syncdata", 1'b0, 16'h00A5, 16'h0000, 1'b0, 1'b0, 4'h0);
    @(negedge clk);

    // Timeout after 999 idle cycles
    tick_byte(8'hA5); tick_byte(8'h34); tick_byte(8'h12);
    repeat (998) @(negedge clk);
    check_eq("to 998 err", err, 1'b0);
    @(negedge clk);
    exp_err = 2;
    check_eq("to 999 err", err, 1'b1);
    check_eq("to errcnt", err_cnt, exp_err);
    check_eq("to out kept", out_pat, 16'h00A5);
    @(negedge clk);
    check_eq("to pulse end", err, 1'b0);

    // 998-cycle gap still completes
    tick_byte(8'hA5); tick_byte(8'h34); tick_byte(8'h12);
    repeat (998) @(negedge clk);
    tick_byte(8'h78); tick_byte(8'h56); tick_byte(8'h25); tick_byte(8'h2D);
    expect_accept("gap998", 1'b1, 16'h1234, 16'h5678, 1'b1, 1'b0, 4'h4);

    // Back-to-back: second sync lands in the S_DONE cycle
    send_packet(8'h34, 8'h12, 8'h78, 8'h56, 8'h24, 8'h2C);
    expect_accept("b2b 2nd", 1'b0, 16'h1234, 16'h5678, 1'b1, 1'b0, 4'h4);
    @(negedge clk);

    // Error counter saturation
    for (int i = 0; i < 260; i++) begin
      send_packet(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
      exp_err = (exp_err < 255) ? exp_err + 1 : 255;
    end
    check_eq("sat err", err, 1'b1);
    check_eq("sat errcnt", err_cnt, exp_err);
    check_eq("sat out kept", out_pat, 16'h1234);
    check_eq("sat sel kept", sel, 4'h4);
    @(negedge clk);

    // Reset mid-packet
    tick_byte(8'hA5); tick_byte(8'h34); tick_byte(8'h12); tick_byte(8'h78);
    rst = 1'b1;
    @(negedge clk);
    check_zero_outputs("midrst");
    rst = 1'b0;
    exp_err = 0;
    @(negedge clk);
    check_eq("midrst err after", err, 1'b0);
    send_packet(8'h34, 8'h12, 8'h78, 8'h56, 8'h25, 8'h2D);
    expect_accept("post rst", 1'b1, 16'h1234, 16'h5678, 1'b1, 1'b0, 4'h4);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
